v4_peak_extractor: RTL

- Back-end consumer of the v4 shaping filter output stream.
- Finds each shaped pulse with a signed threshold and tracks its maximum while above threshold.
- Emits one event per pulse (amplitude plus timestamp of the maximum) over a valid/ready handshake to the readout logic.
- Applies a post-pulse holdoff before re-arming.

---
 rtl/package_settings.sv | 5 +
 rtl/v4_parameters.sv | 15 +
 rtl/v4_sat_counter.sv | 24 ++
 rtl/v4_peak_extractor.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/package_settings.sv
// package_settings: system-wide sizing shared by the v4 signal chain.
//   SIZE_FILTER_DATA - width of one signed shaping-filter sample.
package package_settings;
    localparam int SIZE_FILTER_DATA = 16;
endpackage

// File: rtl/v4_parameters.sv
// v4_parameters: types and default tuning for the v4 back-end blocks.
//   peak_state_t   - peak extractor state (ARMED / TRACK / HOLD)
//   PEAK_*         - default threshold, holdoff, pileup width, timestamp width
package v4_parameters;
    typedef enum logic [1:0] {
        ARMED = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2
    } peak_state_t;

    localparam int PEAK_THRESHOLD  = 100;
    localparam int PEAK_HOLDOFF    = 4;
    localparam int PEAK_MAX_WIDTH  = 32;
    localparam int PEAK_TIME_WIDTH = 16;
endpackage

// File: rtl/v4_sat_counter.sv
// v4_sat_counter: W-bit up counter that sticks at all-ones.
//   clk     - clock
//   rst_n   - asynchronous active-low reset (count -> 0)
//   inc_i   - increment request for this cycle
//   count_o - current count
module v4_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);
    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_q <= '0;
        else if (inc_i && (count_q != {W{1'b1}}))
            count_q <= count_q + 1'b1;
    end

    assign count_o = count_q;
endmodule

// File: rtl/v4_peak_extractor.sv
// v4_peak_extractor: finds pulses above a signed threshold in the shaped
// filter stream, tracks the earliest maximum and emits one event per pulse
// over valid/ready, then waits HOLDOFF cycles before re-arming.
//   clk, reset      - clock, asynchronous active-low reset
//   filter_data     - signed sample, one per clock
//   peak_amplitude  - signed maximum of the held event
//   peak_time       - timestamp of the first sample equal to that maximum
//   peak_valid      - event held; peak_ready accepts it
//   overflow_count  - saturating count of events lost to backpressure
//   pileup_count    - (V4_PEAK_PILEUP_REJECT_EN only) saturating count of
//                     pulses discarded for staying above threshold longer
//                     than MAX_WIDTH cycles
// Build option: define V4_PEAK_PILEUP_REJECT_EN to enable pileup rejection.
module v4_peak_extractor
    import package_settings::*;
    import v4_parameters::*;
#(
    parameter int THRESHOLD  = PEAK_THRESHOLD,
    parameter int HOLDOFF    = PEAK_HOLDOFF,
    parameter int TIME_WIDTH = PEAK_TIME_WIDTH,
    parameter int MAX_WIDTH  = PEAK_MAX_WIDTH
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic signed [SIZE_FILTER_DATA-1:0] filter_data,
    output logic signed [SIZE_FILTER_DATA-1:0] peak_amplitude,
    output logic        [TIME_WIDTH-1:0]       peak_time,
    output logic                               peak_valid,
    input  logic                               peak_ready,
    output logic        [7:0]                  overflow_count
`ifdef V4_PEAK_PILEUP_REJECT_EN
    ,
    output logic        [7:0]                  pileup_count
`endif
);
    localparam int DW  = SIZE_FILTER_DATA;
    localparam int HCW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic signed [DW-1:0] THR = DW'(THRESHOLD);

    peak_state_t            state_q, state_d;
    logic [TIME_WIDTH-1:0]  ts_q;
    logic [HCW-1:0]         hold_cnt_q;
    logic signed [DW-1:0]   max_q;
    logic [TIME_WIDTH-1:0]  tmax_q;
    logic                   valid_q;
    logic signed [DW-1:0]   amp_q;
    logic [TIME_WIDTH-1:0]  time_q;

    logic above, hold_done, flagged;
    logic start, track_up, ends, complete, load, drop;

    assign above     = filter_data > THR;
    assign hold_done = hold_cnt_q == HCW'(HOLDOFF - 1);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ARMED;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARMED:   if (above) state_d = TRACK;
            TRACK:   if (!above) state_d = (HOLDOFF > 0) ? HOLD : ARMED;
            HOLD:    if (hold_done) state_d = ARMED;
            default: state_d = ARMED;
        endcase
    end

    // ---------------- FSM: decoded actions ----------------
    always_comb begin
        start    = (state_q == ARMED) && above;
        track_up = (state_q == TRACK) && above;
        ends     = (state_q == TRACK) && !above;
        complete = ends && !flagged;
        // A completion is only accepted if the output slot is empty or
        // emptying at this very edge; otherwise it is counted and lost.
        load     = complete && (!valid_q || peak_ready);
        drop     = complete && valid_q && !peak_ready;
    end

    // Free-running timestamp; a sample is tagged with the pre-increment value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ts_q <= '0;
        else        ts_q <= ts_q + 1'b1;
    end

    // Running maximum: strict '>' keeps the earliest of equal maxima.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            max_q      <= '0;
            tmax_q     <= '0;
            hold_cnt_q <= '0;
        end else begin
            if (start || (track_up && (filter_data > max_q))) begin
                max_q  <= filter_data;
                tmax_q <= ts_q;
            end
            // Counts HOLD cycles; cleared everywhere else so each holdoff
            // starts from zero.
            if (state_q == HOLD) hold_cnt_q <= hold_cnt_q + 1'b1;
            else                 hold_cnt_q <= '0;
        end
    end

    // Single-entry output slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            amp_q   <= '0;
            time_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            amp_q   <= max_q;
            time_q  <= tmax_q;
        end else if (valid_q && peak_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign peak_valid     = valid_q;
    assign peak_amplitude = amp_q;
    assign peak_time      = time_q;

    v4_sat_counter #(.W(8)) u_ovf_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .inc_i   (drop),
        .count_o (overflow_count)
    );

`ifdef V4_PEAK_PILEUP_REJECT_EN
    localparam int WW = $clog2(MAX_WIDTH + 2);
    logic [WW-1:0] width_q;

    // Number of above-threshold samples in the current pulse, parked at
    // MAX_WIDTH+1 once the pulse is known to be a pileup.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            width_q <= '0;
        else if (start)
            width_q <= WW'(1);
        else if (track_up && (width_q <= WW'(MAX_WIDTH)))
            width_q <= width_q + 1'b1;
    end

    assign flagged = width_q > WW'(MAX_WIDTH);

    v4_sat_counter #(.W(8)) u_pileup_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .inc_i   (ends && flagged),
        .count_o (pileup_count)
    );
`else
    assign flagged = 1'b0;
`endif
endmodule
